// File: rtl/bank_xbar_credit_mgr_if.sv
// ISU request / xbar credit-return bundle for bank_xbar_credit_mgr.
// The master drives requests and returns, and the slave (the credit manager) grants them.
interface bank_xbar_credit_mgr_if;
  logic       isu_cm_req_valid_i;
  logic       isu_cm_req_ready_o;
  logic [1:0] isu_cm_req_ch_id_i;
  logic [2:0] isu_cm_rob_num_o;
  logic [2:0] xbar_cm_credit_rtn_i;

  modport master (
    output isu_cm_req_valid_i,
    output isu_cm_req_ch_id_i,
    output xbar_cm_credit_rtn_i,
    input  isu_cm_req_ready_o,
    input  isu_cm_rob_num_o
  );

  modport slave (
    input  isu_cm_req_valid_i,
    input  isu_cm_req_ch_id_i,
    input  xbar_cm_credit_rtn_i,
    output isu_cm_req_ready_o,
    output isu_cm_rob_num_o
  );
endinterface

// File: rtl/bank_xbar_credit_mgr.sv
// Per-channel ROB credit manager with a drain FSM (RUN/DRAIN/DONE) for three channels.
// Optional sticky protocol-error flag: define BANK_CREDIT_ERR_CHK_EN.
module bank_xbar_credit_mgr #(
  parameter int CREDIT_MAX = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  bank_xbar_credit_mgr_if.slave         bus,
  input  logic                          drain_req_i,
  output logic [3:0]                    cm_ch0_credit_o,
  output logic [3:0]                    cm_ch1_credit_o,
  output logic [3:0]                    cm_ch2_credit_o,
  output logic                          drain_done_o,
  output logic                          cm_err_o
);

  localparam logic [3:0] CMAX = 4'(CREDIT_MAX);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg [3];
  logic [2:0] ptr_reg [3];

  logic       ch_legal;
  logic [3:0] sel_cnt;
  logic [2:0] sel_ptr;
  logic       hs;
  logic [2:0] hs_ch;
  logic [2:0] full_ch;

  always_comb begin
    ch_legal = 1'b0;
    sel_cnt  = '0;
    sel_ptr  = '0;
    case (bus.isu_cm_req_ch_id_i)
      2'd0: begin ch_legal = 1'b1; sel_cnt = cnt_reg[0]; sel_ptr = ptr_reg[0]; end
      2'd1: begin ch_legal = 1'b1; sel_cnt = cnt_reg[1]; sel_ptr = ptr_reg[1]; end
      2'd2: begin ch_legal = 1'b1; sel_cnt = cnt_reg[2]; sel_ptr = ptr_reg[2]; end
      default: ;
    endcase
  end

  // Ready depends only on registered state and the channel id, never on valid.
  assign bus.isu_cm_req_ready_o = (state_reg == RUN) && ch_legal && (sel_cnt != 4'd0);
  assign bus.isu_cm_rob_num_o   = sel_ptr;
  assign hs = bus.isu_cm_req_valid_i && bus.isu_cm_req_ready_o;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      assign hs_ch[gi]   = hs && (bus.isu_cm_req_ch_id_i == 2'(gi));
      assign full_ch[gi] = (cnt_reg[gi] == CMAX);
    end
  endgenerate

  // A grant and a return on the same channel cancel; a return to a full counter saturates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < 3; n++) begin
        cnt_reg[n] <= CMAX;
        ptr_reg[n] <= 3'd0;
      end
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (hs_ch[n] && !bus.xbar_cm_credit_rtn_i[n])
          cnt_reg[n] <= cnt_reg[n] - 4'd1;
        else if (!hs_ch[n] && bus.xbar_cm_credit_rtn_i[n] && !full_ch[n])
          cnt_reg[n] <= cnt_reg[n] + 4'd1;
        if (hs_ch[n])
          ptr_reg[n] <= ptr_reg[n] + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= RUN;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (drain_req_i) state_next = DRAIN;
      DRAIN:   if (&full_ch)    state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign drain_done_o    = (state_reg == DONE);
  assign cm_ch0_credit_o = cnt_reg[0];
  assign cm_ch1_credit_o = cnt_reg[1];
  assign cm_ch2_credit_o = cnt_reg[2];

`ifdef BANK_CREDIT_ERR_CHK_EN
  logic [2:0] ovf_ch;
  logic       err_reg;
  logic       err_set;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_ovf
      assign ovf_ch[gi] = bus.xbar_cm_credit_rtn_i[gi] && full_ch[gi] && !hs_ch[gi];
    end
  endgenerate

  assign err_set = (|ovf_ch) || (bus.isu_cm_req_valid_i && (bus.isu_cm_req_ch_id_i == 2'd3));

  always_ff @(posedge clk_i) begin
    if (rst_i)        err_reg <= 1'b0;
    else if (err_set) err_reg <= 1'b1;
  end

  assign cm_err_o = err_reg;
`else
  assign cm_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bank_xbar_credit_mgr.sv
// Directed bench for bank_xbar_credit_mgr: a per-cycle behavioural model plus literal
// expectations for the credit, pointer-wrap, drain and reset scenarios.
module tb_bank_xbar_credit_mgr;
  localparam int MAXC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drain_req = 1'b0;
  logic [3:0] credit0, credit1, credit2;
  logic drain_done, err;

  int n_cmp = 0;
  int n_fail = 0;
  bit started = 1'b0;

  bank_xbar_credit_mgr_if bus();

  bank_xbar_credit_mgr #(.CREDIT_MAX(MAXC)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus.slave),
    .drain_req_i    (drain_req),
    .cm_ch0_credit_o(credit0),
    .cm_ch1_credit_o(credit1),
    .cm_ch2_credit_o(credit2),
    .drain_done_o   (drain_done),
    .cm_err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: free credits, next ROB slot, and phase (0 run, 1 drain, 2 done).
  int m_cnt[3];
  int m_ptr[3];
  int m_st;
  bit m_err;

  function automatic bit m_ready();
    int ch;
    ch = int'(bus.isu_cm_req_ch_id_i);
    return (m_st == 0) && (ch < 3) && (m_cnt[ch] > 0);
  endfunction

  function automatic int m_rob();
    int ch;
    ch = int'(bus.isu_cm_req_ch_id_i);
    return (ch < 3) ? m_ptr[ch] : 0;
  endfunction

  initial begin
    for (int n = 0; n < 3; n++) begin m_cnt[n] = MAXC; m_ptr[n] = 0; end
    m_st = 0;
    m_err = 1'b0;
  end

  always @(posedge clk) begin : model
    bit hs;
    bit all_full;
    int ch;
    if (rst) begin
      for (int n = 0; n < 3; n++) begin m_cnt[n] = MAXC; m_ptr[n] = 0; end
      m_st = 0;
      m_err = 1'b0;
    end else begin
      ch = int'(bus.isu_cm_req_ch_id_i);
      hs = bus.isu_cm_req_valid_i && m_ready();
      all_full = (m_cnt[0] == MAXC) && (m_cnt[1] == MAXC) && (m_cnt[2] == MAXC);
`ifdef BANK_CREDIT_ERR_CHK_EN
      if (bus.isu_cm_req_valid_i && ch == 3) m_err = 1'b1;
`endif
      for (int n = 0; n < 3; n++) begin
        int nv;
        nv = m_cnt[n] - ((hs && ch == n) ? 1 : 0) + (bus.xbar_cm_credit_rtn_i[n] ? 1 : 0);
        if (nv > MAXC) begin
          nv = MAXC;
`ifdef BANK_CREDIT_ERR_CHK_EN
          m_err = 1'b1;
`endif
        end
        m_cnt[n] = nv;
        if (hs && ch == n) m_ptr[n] = (m_ptr[n] + 1) % 8;
      end
      case (m_st)
        0: if (drain_req) m_st = 1;
        1: if (all_full) m_st = 2;
        default: m_st = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ready", 8'(bus.isu_cm_req_ready_o), 8'(m_ready()));
      chk("rob_num", 8'(bus.isu_cm_rob_num_o), 8'(m_rob()));
      chk("credit0", 8'(credit0), 8'(m_cnt[0]));
      chk("credit1", 8'(credit1), 8'(m_cnt[1]));
      chk("credit2", 8'(credit2), 8'(m_cnt[2]));
      chk("drain_done", 8'(drain_done), 8'(m_st == 2));
      chk("err", 8'(err), 8'(m_err));
    end
  end

  task automatic drive(input bit v, input logic [1:0] ch, input logic [2:0] rtn,
                       input bit drn, input bit rs);
    @(posedge clk);
    #1;
    bus.isu_cm_req_valid_i   = v;
    bus.isu_cm_req_ch_id_i   = ch;
    bus.xbar_cm_credit_rtn_i = rtn;
    drain_req = drn;
    rst = rs;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.isu_cm_req_valid_i   = 1'b0;
    bus.isu_cm_req_ch_id_i   = 2'd0;
    bus.xbar_cm_credit_rtn_i = 3'b000;

    drive(0, 0, 3'b000, 0, 1);
    drive(0, 0, 3'b000, 0, 1);
    drive(0, 1, 3'b000, 0, 0);
    started = 1'b1;
    chk("rst_ready_ch1", 8'(bus.isu_cm_req_ready_o), 8'd1);
    chk("rst_credit0", 8'(credit0), 8'd8);
    chk("rst_done", 8'(drain_done), 8'd0);
    chk("rst_err", 8'(err), 8'd0);

    // Eight back-to-back grants on ch1 drain it completely.
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 3'b000, 0, 0);
      chk("ch1_rob", 8'(bus.isu_cm_rob_num_o), 8'(i));
      chk("ch1_credit", 8'(credit1), 8'(8 - i));
    end
    drive(1, 1, 3'b000, 0, 0);
    chk("ch1_empty_ready", 8'(bus.isu_cm_req_ready_o), 8'd0);
    chk("ch1_empty_credit", 8'(credit1), 8'd0);
    chk("ch0_untouched", 8'(credit0), 8'd8);
    chk("ch2_untouched", 8'(credit2), 8'd8);
    for (int i = 0; i < 8; i++) drive(0, 0, 3'b010, 0, 0);

    // ch0 empty with pointer wrapped to 0; return and request together.
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 3'b000, 0, 0);
      chk("ch0_rob", 8'(bus.isu_cm_rob_num_o), 8'(i));
    end
    drive(1, 0, 3'b001, 0, 0);
    chk("ch0_empty_ready", 8'(bus.isu_cm_req_ready_o), 8'd0);
    drive(1, 0, 3'b000, 0, 0);
    chk("ch0_ret_ready", 8'(bus.isu_cm_req_ready_o), 8'd1);
    chk("ch0_wrap_rob", 8'(bus.isu_cm_rob_num_o), 8'd0);
    chk("ch0_ret_credit", 8'(credit0), 8'd1);
    drive(0, 0, 3'b000, 0, 0);
    chk("ch0_back_zero", 8'(credit0), 8'd0);
    for (int i = 0; i < 8; i++) drive(0, 0, 3'b001, 0, 0);

    // ch2 at 3 credits: simultaneous grant and return keeps the count.
    for (int i = 0; i < 5; i++) drive(1, 2, 3'b000, 0, 0);
    drive(1, 2, 3'b100, 0, 0);
    chk("ch2_cnt3", 8'(credit2), 8'd3);
    chk("ch2_rob5", 8'(bus.isu_cm_rob_num_o), 8'd5);
    drive(0, 2, 3'b000, 0, 0);
    chk("ch2_cnt_same", 8'(credit2), 8'd3);
    chk("ch2_ptr_inc", 8'(bus.isu_cm_rob_num_o), 8'd6);
    for (int i = 0; i < 5; i++) drive(0, 0, 3'b100, 0, 0);

    // Drain with five ch0 credits outstanding.
    for (int i = 0; i < 5; i++) drive(1, 0, 3'b000, 0, 0);
    drive(0, 0, 3'b000, 1, 0);
    chk("pre_drain_credit0", 8'(credit0), 8'd3);
    drive(1, 0, 3'b000, 1, 0);
    chk("drain_ready_low", 8'(bus.isu_cm_req_ready_o), 8'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 3'b001, 1, 0);
      chk("drain_no_grant", 8'(bus.isu_cm_req_ready_o), 8'd0);
    end
    drive(0, 0, 3'b000, 1, 0);
    chk("drain_full", 8'(credit0), 8'd8);
    chk("drain_not_yet", 8'(drain_done), 8'd0);
    drive(0, 0, 3'b000, 0, 0);
    chk("drain_pulse", 8'(drain_done), 8'd1);
    drive(0, 0, 3'b000, 0, 0);
    chk("drain_pulse_end", 8'(drain_done), 8'd0);
    chk("run_ready", 8'(bus.isu_cm_req_ready_o), 8'd1);

    // Return to a full counter, then an illegal channel id.
    drive(0, 0, 3'b010, 0, 0);
    drive(0, 0, 3'b000, 0, 0);
    chk("sat_credit1", 8'(credit1), 8'd8);
`ifdef BANK_CREDIT_ERR_CHK_EN
    chk("err_set", 8'(err), 8'd1);
`else
    chk("err_zero", 8'(err), 8'd0);
`endif
    drive(1, 3, 3'b000, 0, 0);
    chk("ch3_ready", 8'(bus.isu_cm_req_ready_o), 8'd0);
    chk("ch3_rob", 8'(bus.isu_cm_rob_num_o), 8'd0);
    drive(0, 0, 3'b000, 0, 0);
    chk("ch3_no_change", 8'(credit0), 8'd8);

    // Reset during DRAIN with counts {2,8,5}.
    for (int i = 0; i < 6; i++) drive(1, 0, 3'b000, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 2, 3'b000, 0, 0);
    drive(0, 0, 3'b000, 1, 0);
    chk("pre_rst_c0", 8'(credit0), 8'd2);
    chk("pre_rst_c2", 8'(credit2), 8'd5);
    drive(0, 0, 3'b000, 1, 0);
    chk("in_drain_ready", 8'(bus.isu_cm_req_ready_o), 8'd0);
    drive(1, 0, 3'b111, 1, 1);
    drive(0, 0, 3'b000, 0, 0);
    chk("post_rst_c0", 8'(credit0), 8'd8);
    chk("post_rst_c2", 8'(credit2), 8'd8);
    chk("post_rst_ready", 8'(bus.isu_cm_req_ready_o), 8'd1);
    chk("post_rst_rob0", 8'(bus.isu_cm_rob_num_o), 8'd0);
    chk("post_rst_done", 8'(drain_done), 8'd0);
    chk("post_rst_err", 8'(err), 8'd0);
    drive(0, 2, 3'b000, 0, 0);
    chk("post_rst_rob2", 8'(bus.isu_cm_rob_num_o), 8'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 3'b000, 0, 0);
      chk("no_late_pulse", 8'(drain_done), 8'd0);
    end

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
